pwm_capture: RTL

//   Receive-side counterpart of the pwm generator: measures an incoming PWM waveform and recovers the
//   (compare, top) pair that produced it. Used to loop io_PMOD PWM back into the FPGA, or to capture

---
 rtl/pwm_capture_if.sv | 29 ++
 rtl/pwm_capture.sv | 98 +++++++++
 2 files changed

// File: rtl/pwm_capture_if.sv
// ============================================================================
// Module   : pwm_capture_if
// Brief    : PWM input plus recovered compare/top measurement bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pwm_capture_if #(
    parameter int CNT_W = 9
);
    logic             i_pwm;
    logic [CNT_W-1:0] o_compare;
    logic [CNT_W-1:0] o_top;
    logic             o_valid;
    logic             o_timeout;
    logic             o_level;

    modport slave (
        input  i_pwm,
        output o_compare, o_top, o_valid, o_timeout, o_level
    );

    modport master (
        output i_pwm,
        input  o_compare, o_top, o_valid, o_timeout, o_level
    );
endinterface

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// Module   : pwm_capture
// Brief    : Measures an asynchronous PWM input and recovers its (compare, top).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_capture #(
    parameter int CNT_W      = 9,
    parameter int MAX_PERIOD = 511
) (
    input  wire logic     i_clk,
    input  wire logic     i_rst_n,
    pwm_capture_if.slave  bus
);

    localparam logic [1:0]       S_SEEK = 2'd0;
    localparam logic [1:0]       S_HIGH = 2'd1;
    localparam logic [1:0]       S_LOW  = 2'd2;
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_spwm;
    logic             r_sprev;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_compare;
    logic [CNT_W-1:0] r_top;
    logic             r_valid;
    logic             r_timeout;

    logic             w_rise;
    logic             w_sat;

    assign w_rise = r_spwm & ~r_sprev;
    assign w_sat  = (r_per == C_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_spwm    <= 1'b0;
            r_sprev   <= 1'b0;
            r_state   <= S_SEEK;
            r_per     <= '0;
            r_hi      <= '0;
            r_compare <= '0;
            r_top     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_sync1 <= bus.i_pwm;
            r_spwm  <= r_sync1;
            r_sprev <= r_spwm;
            r_valid <= 1'b0;

            // A rise on the saturation cycle still closes the period normally.
            if (w_rise) begin
                if (r_state == S_LOW) begin
                    r_compare <= r_hi;
                    r_top     <= r_per - C_ONE;
                    r_valid   <= 1'b1;
                    r_timeout <= 1'b0;
                end
                r_per   <= C_ONE;
                r_hi    <= C_ONE;
                r_state <= S_HIGH;
            end else if (w_sat) begin
                r_timeout <= 1'b1;
                r_state   <= S_SEEK;
            end else begin
                case (r_state)
                    S_SEEK: r_per <= r_per + C_ONE;
                    S_HIGH: begin
                        r_per <= r_per + C_ONE;
                        if (r_spwm) begin
                            r_hi <= r_hi + C_ONE;
                        end else begin
                            r_state <= S_LOW;
                        end
                    end
                    S_LOW:  r_per <= r_per + C_ONE;
                    default: r_state <= S_SEEK;
                endcase
            end
        end
    end

    assign bus.o_compare = r_compare;
    assign bus.o_top     = r_top;
    assign bus.o_valid   = r_valid;
    assign bus.o_timeout = r_timeout;
    assign bus.o_level   = r_spwm;

endmodule

`default_nettype wire
